// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI bus (MOSI, SCLK, selects) among several masters.
// Holds a grant for a whole transaction, forces an idle guard gap, and revokes stalled owners.
module spi_bus_arbiter #(
  parameter int NREQ    = 3,
  parameter int NSS     = 3,
  parameter int GUARD   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     gnt,
  input  logic [NREQ-1:0]     req_mosi,
  input  logic [NREQ-1:0]     req_sclk,
  input  logic [NREQ*NSS-1:0] req_ss,
  output logic                req_miso,
  output logic                bus_mosi,
  output logic                bus_sclk,
  output logic [NSS-1:0]      bus_ss,
  input  logic                bus_miso,
  output logic                busy,
  output logic                timeout_err,
  input  logic                err_clr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [IW-1:0]     ptr_reg, ptr_next;
  logic [IW-1:0]     owner_reg, owner_next;
  logic [NREQ-1:0]   lockout_reg, lockout_next;
  logic [WW-1:0]     wdog_reg, wdog_next;
  logic [GW-1:0]     guard_reg, guard_next;
  logic              sclk_prev_reg, sclk_prev_next;
  logic              bus_mosi_reg, bus_mosi_next;
  logic              bus_sclk_reg, bus_sclk_next;
  logic [NSS-1:0]    bus_ss_reg, bus_ss_next;
  logic              timeout_err_reg, timeout_err_next;

  logic [NREQ-1:0]   eligible;
  logic              found;
  logic [IW-1:0]     winner;
  int                cand;
  logic              own_sclk;
  logic              sclk_changed;
  logic [NREQ-1:0]   lock_set;
  logic              err_set;

  assign eligible     = req & ~lockout_reg;
  assign own_sclk     = req_sclk[owner_reg];
  assign sclk_changed = (own_sclk != sclk_prev_reg);

  // First eligible requester searching upward from the pointer, wrapping at NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = IW'(cand);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    ptr_next       = ptr_reg;
    owner_next     = owner_reg;
    wdog_next      = wdog_reg;
    guard_next     = guard_reg;
    sclk_prev_next = sclk_prev_reg;
    bus_mosi_next  = 1'b1;
    bus_sclk_next  = 1'b0;
    bus_ss_next    = '1;
    lock_set       = '0;
    err_set        = 1'b0;

    case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (found) begin
          gnt_next       = NREQ'(1) << winner;
          owner_next     = winner;
          ptr_next       = (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
          wdog_next      = '0;
          sclk_prev_next = req_sclk[winner];
          state_next     = GRANT;
        end
      end
      GRANT: begin
        sclk_prev_next = own_sclk;
        wdog_next      = sclk_changed ? '0 : wdog_reg + 1'b1;
        // A timeout outranks a simultaneous request drop so the stall is still flagged.
        if (!sclk_changed && wdog_reg == WW'(TIMEOUT - 2)) begin
          err_set             = 1'b1;
          lock_set[owner_reg] = 1'b1;
          gnt_next            = '0;
          guard_next          = GW'(GUARD - 1);
          state_next          = RELEASE;
        end else if (!req[owner_reg]) begin
          gnt_next   = '0;
          guard_next = GW'(GUARD - 1);
          state_next = RELEASE;
        end else begin
          bus_mosi_next = req_mosi[owner_reg];
          bus_sclk_next = own_sclk;
          bus_ss_next   = req_ss[owner_reg*NSS +: NSS];
        end
      end
      RELEASE: begin
        gnt_next = '0;
        if (guard_reg == '0) state_next = IDLE;
        else guard_next = guard_reg - 1'b1;
      end
      default: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
    endcase

    // Lockout persists until the stalled master is seen with req low.
    lockout_next     = (lockout_reg & req) | lock_set;
    timeout_err_next = err_set | (timeout_err_reg & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      gnt_reg         <= '0;
      ptr_reg         <= '0;
      owner_reg       <= '0;
      lockout_reg     <= '0;
      wdog_reg        <= '0;
      guard_reg       <= '0;
      sclk_prev_reg   <= 1'b0;
      bus_mosi_reg    <= 1'b1;
      bus_sclk_reg    <= 1'b0;
      bus_ss_reg      <= '1;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      gnt_reg         <= gnt_next;
      ptr_reg         <= ptr_next;
      owner_reg       <= owner_next;
      lockout_reg     <= lockout_next;
      wdog_reg        <= wdog_next;
      guard_reg       <= guard_next;
      sclk_prev_reg   <= sclk_prev_next;
      bus_mosi_reg    <= bus_mosi_next;
      bus_sclk_reg    <= bus_sclk_next;
      bus_ss_reg      <= bus_ss_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign gnt         = gnt_reg;
  assign bus_mosi    = bus_mosi_reg;
  assign bus_sclk    = bus_sclk_reg;
  assign bus_ss      = bus_ss_reg;
  assign busy        = (state_reg != IDLE);
  assign timeout_err = timeout_err_reg;
  assign req_miso    = bus_miso;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural owner/gap model of the arbitration rules.
module tb_spi_bus_arbiter;
  localparam int NREQ = 3, NSS = 3, GUARD = 4, TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req, req_mosi, req_sclk, gnt;
  logic [NREQ*NSS-1:0] req_ss;
  logic                req_miso, bus_mosi, bus_sclk, bus_miso, busy, timeout_err, err_clr;
  logic [NSS-1:0]      bus_ss;

  spi_bus_arbiter #(.NREQ(NREQ), .NSS(NSS), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .req_mosi(req_mosi),
    .req_sclk(req_sclk), .req_ss(req_ss), .req_miso(req_miso), .bus_mosi(bus_mosi),
    .bus_sclk(bus_sclk), .bus_ss(bus_ss), .bus_miso(bus_miso), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how many guard cycles remain, quiet-SCLK count.
  int              m_owner, m_gap, m_ptr, m_quiet;
  logic            m_last, m_err, m_busy, m_mosi, m_sclk;
  logic [NREQ-1:0] m_lock, m_gnt;
  logic [NSS-1:0]  m_ss;

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0; m_quiet = 0; m_last = 1'b0;
    m_err = 1'b0; m_lock = '0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] set_lock;
    logic            err_set;
    set_lock = '0; err_set = 1'b0;
    m_gnt = '0; m_mosi = 1'b1; m_sclk = 1'b0; m_ss = '1;
    if (m_gap > 0) begin
      m_gap--;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (m_owner < 0 && req[j] && !m_lock[j]) m_owner = j;
      end
      if (m_owner >= 0) begin
        m_ptr = (m_owner + 1) % NREQ;
        m_quiet = 0;
        m_last = req_sclk[m_owner];
        m_gnt[m_owner] = 1'b1;
      end
    end else begin
      if (req_sclk[m_owner] != m_last) m_quiet = 0;
      else m_quiet++;
      m_last = req_sclk[m_owner];
      if (m_quiet == TIMEOUT - 1) begin
        err_set = 1'b1; set_lock[m_owner] = 1'b1; m_owner = -1; m_gap = GUARD;
      end else if (!req[m_owner]) begin
        m_owner = -1; m_gap = GUARD;
      end else begin
        m_gnt[m_owner] = 1'b1;
        m_mosi = req_mosi[m_owner];
        m_sclk = req_sclk[m_owner];
        m_ss   = req_ss[m_owner*NSS +: NSS];
      end
    end
    m_lock = (m_lock & req) | set_lock;
    m_err  = err_set | (m_err & !err_clr);
    m_busy = (m_owner >= 0) || (m_gap > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("gnt", gnt, m_gnt);
    check("bus_mosi", bus_mosi, m_mosi);
    check("bus_sclk", bus_sclk, m_sclk);
    check("bus_ss", bus_ss, m_ss);
    check("busy", busy, m_busy);
    check("timeout_err", timeout_err, m_err);
    check("req_miso", req_miso, bus_miso);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req = 3'($urandom); req_mosi = 3'($urandom); req_sclk = 3'($urandom);
      req_ss = 9'($urandom); err_clr = 1'($urandom); bus_miso = 1'($urandom);
      @(posedge clk); #1;
      check("rst_gnt", gnt, 0);
      check("rst_ss", bus_ss, 3'b111);
      check("rst_sclk", bus_sclk, 0);
      check("rst_mosi", bus_mosi, 1);
      check("rst_busy", busy, 0);
      check("rst_err", timeout_err, 0);
    end
    req = '0; req_sclk = '0; req_mosi = '0; req_ss = '1; err_clr = 1'b0;
    reset = 1'b0;
    model_reset();
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Ticks until a grant appears; n is the number of ticks spent.
  task automatic wait_grant(output int idx, output int n);
    n = 0;
    do begin tick(); n++; end while (gnt == '0 && n < 40);
    if (gnt == '0) check("grant_wait_expired", 0, 1);
    idx = oh_idx(gnt);
  endtask

  logic [NREQ-1:0] stall;
  int idx, n, cnt, regrant;

  initial begin
    reset = 1'b1; req = '0; req_mosi = '0; req_sclk = '0; req_ss = '1;
    err_clr = 1'b0; bus_miso = 1'b0;
    #2;

    // Single owner with ss=110 and a clean guard gap after release.
    do_reset();
    req = 3'b001; req_ss = 9'b111_111_110;
    tick();
    check("single_gnt", gnt, 3'b001);
    for (int k = 0; k < 10; k++) begin
      req_sclk[0] = ~req_sclk[0]; req_mosi[0] = 1'($urandom); bus_miso = 1'($urandom);
      tick();
    end
    req = '0;
    tick();
    check("single_drop_gnt", gnt, 0);
    cnt = 0;
    for (int k = 0; k < 20 && busy; k++) begin cnt++; tick(); end
    check("guard_len", cnt, GUARD);

    // Round robin with everyone requesting: order 0,1,2,0.
    do_reset();
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      wait_grant(idx, n);
      $display("[TB] rr grant %0d -> requester %0d after %0d cycles", g, idx, n);
      check("rr_order", idx, g % NREQ);
      if (g > 0) check("rr_gap_ok", (n >= GUARD + 1), 1);
      if (idx >= 0) begin
        for (int e = 0; e < 8; e++) begin req_sclk[idx] = ~req_sclk[idx]; tick(); end
        req[idx] = 1'b0;
        tick();
        req[idx] = 1'b1;
      end
    end

    // Fairness across the wrap: after a grant to 2, requester 0 goes ahead of 2.
    do_reset();
    req = 3'b100;
    wait_grant(idx, n);
    check("wrap_first", idx, 2);
    for (int e = 0; e < 4; e++) begin req_sclk[2] = ~req_sclk[2]; tick(); end
    req = '0;
    for (int k = 0; k < 20 && (busy || gnt != '0); k++) tick();
    req = 3'b101;
    wait_grant(idx, n);
    check("wrap_fair", idx, 0);

    // Watchdog: requester 1 stalls SCLK and is revoked, then locked out until req drops.
    do_reset();
    req = 3'b010;
    wait_grant(idx, n);
    check("wd_grant", idx, 1);
    for (int e = 0; e < 3; e++) begin req_sclk[1] = ~req_sclk[1]; tick(); end
    n = 0;
    do begin tick(); n++; end while (gnt != '0 && n < 40);
    check("wd_cycles", n, TIMEOUT - 1);
    check("wd_err", timeout_err, 1);
    regrant = 0;
    for (int k = 0; k < 30; k++) begin tick(); if (gnt[1]) regrant = 1; end
    check("wd_no_regrant", regrant, 0);
    req[1] = 1'b0;
    tick();
    req[1] = 1'b1;
    wait_grant(idx, n);
    check("wd_regrant", idx, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("wd_err_clr", timeout_err, 0);

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    req = 3'b001; req_ss = 9'b111_111_101;
    wait_grant(idx, n);
    req_sclk[0] = 1'b1;
    tick();
    check("pre_rst_ss", bus_ss, 3'b101);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ss", bus_ss, 3'b111);
    check("async_rst_gnt", gnt, 0);
    check("async_rst_busy", busy, 0);

    // Randomized traffic with sticky requests and occasional SCLK stalls.
    do_reset();
    stall = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 11) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 39) == 0) stall[i] = ~stall[i];
        if (!stall[i] && $urandom_range(0, 2) == 0) req_sclk[i] = ~req_sclk[i];
      end
      req_mosi = 3'($urandom);
      req_ss   = 9'($urandom);
      err_clr  = ($urandom_range(0, 19) == 0);
      bus_miso = 1'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
